// File: rtl/ustc_psum_pkg.sv
// Shared types and default parameters for the partial-sum buffer.
// Holds the FSM state enum and the default geometry constants.
package ustc_psum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } psum_state_t;

  localparam int DEF_M       = 16;
  localparam int DEF_N       = 16;
  localparam int DEF_NUM_IN  = 32;
  localparam int DEF_DW_DATA = 8;
  localparam int DEF_DW_ACC  = 16;
  localparam int DEF_DW_ROW  = 4;
  localparam int DEF_DW_COL  = 4;

endpackage

// File: rtl/ustc_psum_row_adder.sv
// Reduces the masked lanes whose row index equals ROW into one sum.
// Ports: in_data/in_row/in_mask (beat lanes) -> sum (signed, widened).
module ustc_psum_row_adder
  import ustc_psum_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int DW_DATA = DEF_DW_DATA,
  parameter int DW_ACC  = DEF_DW_ACC,
  parameter int DW_ROW  = DEF_DW_ROW,
  parameter int ROW     = 0,
  parameter int SW      = DW_ACC + $clog2(NUM_IN)
) (
  input  logic [NUM_IN*DW_DATA-1:0] in_data,
  input  logic [NUM_IN*DW_ROW-1:0]  in_row,
  input  logic [NUM_IN-1:0]         in_mask,
  output logic [SW-1:0]             sum
);

  logic [DW_DATA-1:0] lane;

  always_comb begin
    sum  = '0;
    lane = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      lane = in_data[i*DW_DATA +: DW_DATA];
      if (in_mask[i] &&
          in_row[i*DW_ROW +: DW_ROW] == DW_ROW'(ROW))
        sum = sum + {{(SW-DW_DATA){lane[DW_DATA-1]}}, lane};
    end
  end

endmodule

// File: rtl/ustc_psum_accum_buf.sv
// M x N partial-sum accumulator tile buffer; drains columns 0..N-1.
// Ports: clk, rst (sync, high); in_* beat handshake; out_* column
// handshake; sat_flag. Optional clamping: define USTC_PSUM_SAT_EN.
module ustc_psum_accum_buf
  import ustc_psum_pkg::*;
#(
  parameter int M       = DEF_M,
  parameter int N       = DEF_N,
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int DW_DATA = DEF_DW_DATA,
  parameter int DW_ACC  = DEF_DW_ACC,
  parameter int DW_ROW  = DEF_DW_ROW,
  parameter int DW_COL  = DEF_DW_COL
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW_COL-1:0]         in_col,
  input  logic [NUM_IN*DW_DATA-1:0] in_data,
  input  logic [NUM_IN*DW_ROW-1:0]  in_row,
  input  logic [NUM_IN-1:0]         in_mask,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW_COL-1:0]         out_col,
  output logic [M*DW_ACC-1:0]       out_data,
  output logic                      sat_flag
);

  localparam int SW = DW_ACC + $clog2(NUM_IN);

  psum_state_t       state;
  logic [DW_COL-1:0] col_q;
  logic [DW_ACC-1:0] acc [N][M];
  logic [SW-1:0]     sums [M];
  logic [DW_ACC-1:0] cur [M];
  logic [DW_ACC-1:0] upd [M];
  logic [SW:0]       tot [M];
  logic              accept;
  logic              out_fire;

  // Handshake outputs are forced low combinationally while rst is high.
  assign in_ready  = !rst && (state != DRAIN);
  assign out_valid = !rst && (state == DRAIN);
  assign out_col   = rst ? '0 : col_q;
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  for (genvar r = 0; r < M; r++) begin : g_row
    ustc_psum_row_adder #(
      .NUM_IN (NUM_IN),
      .DW_DATA(DW_DATA),
      .DW_ACC (DW_ACC),
      .DW_ROW (DW_ROW),
      .ROW    (r),
      .SW     (SW)
    ) u_add (
      .in_data(in_data),
      .in_row (in_row),
      .in_mask(in_mask),
      .sum    (sums[r])
    );
  end

  always_comb begin
    for (int r = 0; r < M; r++) cur[r] = '0;
    out_data = '0;
    for (int c = 0; c < N; c++)
      for (int r = 0; r < M; r++) begin
        if (in_col == DW_COL'(c)) cur[r] = acc[c][r];
        if (col_q == DW_COL'(c))
          out_data[r*DW_ACC +: DW_ACC] = acc[c][r];
      end
  end

`ifdef USTC_PSUM_SAT_EN
  localparam logic signed [SW:0] MAXV =
    {{(SW+2-DW_ACC){1'b0}}, {(DW_ACC-1){1'b1}}};
  localparam logic signed [SW:0] MINV =
    {{(SW+2-DW_ACC){1'b1}}, {(DW_ACC-1){1'b0}}};

  logic [M-1:0] clamp;

  always_comb begin
    clamp = '0;
    for (int r = 0; r < M; r++) begin
      tot[r] = {{(SW+1-DW_ACC){cur[r][DW_ACC-1]}}, cur[r]}
             + {sums[r][SW-1], sums[r]};
      upd[r] = tot[r][DW_ACC-1:0];
      if ($signed(tot[r]) > MAXV) begin
        upd[r]   = MAXV[DW_ACC-1:0];
        clamp[r] = 1'b1;
      end else if ($signed(tot[r]) < MINV) begin
        upd[r]   = MINV[DW_ACC-1:0];
        clamp[r] = 1'b1;
      end
    end
  end

  logic sat_q;

  always_ff @(posedge clk) begin
    if (rst)
      sat_q <= 1'b0;
    else if (accept && in_col < DW_COL'(N) && |clamp)
      sat_q <= 1'b1;
  end

  assign sat_flag = !rst && sat_q;
`else
  always_comb begin
    for (int r = 0; r < M; r++) begin
      tot[r] = {{(SW+1-DW_ACC){cur[r][DW_ACC-1]}}, cur[r]}
             + {sums[r][SW-1], sums[r]};
      upd[r] = DW_ACC'(tot[r]);
    end
  end

  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N; c++)
        for (int r = 0; r < M; r++)
          acc[c][r] <= '0;
    end else begin
      for (int c = 0; c < N; c++)
        for (int r = 0; r < M; r++)
          if (accept && in_col == DW_COL'(c))
            acc[c][r] <= upd[r];
          else if (out_fire && col_q == DW_COL'(c))
            acc[c][r] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col_q <= '0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (accept) state <= in_last ? DRAIN : ACCUM;
        end
        DRAIN: begin
          if (out_ready) begin
            if (col_q == DW_COL'(N-1)) begin
              state <= IDLE;
              col_q <= '0;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ustc_psum_accum_buf.sv
// Directed bench for ustc_psum_accum_buf with a small tile geometry.
// Expected column contents are hand-set per scenario in exp_acc.
module tb_ustc_psum_accum_buf;

  localparam int M = 8, N = 6, NUM_IN = 8;
  localparam int DW_DATA = 8, DW_ACC = 8;
  localparam int DW_ROW = 4, DW_COL = 4;

  logic                      clk = 0;
  logic                      rst = 1;
  logic                      in_valid = 0;
  logic                      in_ready;
  logic [DW_COL-1:0]         in_col = '0;
  logic [NUM_IN*DW_DATA-1:0] in_data = '0;
  logic [NUM_IN*DW_ROW-1:0]  in_row = '0;
  logic [NUM_IN-1:0]         in_mask = '0;
  logic                      in_last = 0;
  logic                      out_valid;
  logic                      out_ready = 0;
  logic [DW_COL-1:0]         out_col;
  logic [M*DW_ACC-1:0]       out_data;
  logic                      sat_flag;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_acc [N][M];

  ustc_psum_accum_buf #(
    .M(M), .N(N), .NUM_IN(NUM_IN), .DW_DATA(DW_DATA),
    .DW_ACC(DW_ACC), .DW_ROW(DW_ROW), .DW_COL(DW_COL)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_col(in_col), .in_data(in_data), .in_row(in_row),
    .in_mask(in_mask), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_col(out_col), .out_data(out_data),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [M*DW_ACC-1:0] pack_col(input int c);
    logic [M*DW_ACC-1:0] v;
    v = '0;
    for (int r = 0; r < M; r++)
      v[r*DW_ACC +: DW_ACC] = DW_ACC'(exp_acc[c][r]);
    return v;
  endfunction

  task automatic clear_exp();
    for (int c = 0; c < N; c++)
      for (int r = 0; r < M; r++)
        exp_acc[c][r] = 0;
  endtask

  task automatic set_lane(input int i, input int row,
                          input int data);
    in_row[i*DW_ROW +: DW_ROW]    = DW_ROW'(row);
    in_data[i*DW_DATA +: DW_DATA] = DW_DATA'(data);
  endtask

  task automatic beat(input int col,
                      input logic [NUM_IN-1:0] mask,
                      input bit last);
    @(negedge clk);
    in_valid = 1;
    in_col   = DW_COL'(col);
    in_mask  = mask;
    in_last  = last;
    check("beat_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    in_last  = 0;
    in_mask  = '0;
    in_data  = '0;
    in_row   = '0;
    if (last) begin
      check("last_valid", out_valid, 1);
      check("last_col", out_col, 0);
    end
  endtask

  task automatic drain();
    out_ready = 1;
    for (int c = 0; c < N; c++) begin
      int n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("drain_valid", out_valid, 1);
      check("drain_col", out_col, c);
      check("drain_data", out_data, pack_col(c));
      @(negedge clk);
    end
    out_ready = 0;
    check("idle_ready", in_ready, 1);
    check("idle_valid", out_valid, 0);
    clear_exp();
  endtask

  initial begin
    logic [M*DW_ACC-1:0] held;
    clear_exp();

    // reset state
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 0);
    check("rst_col", out_col, 0);
    check("rst_sat", sat_flag, 0);
    @(negedge clk);
    rst = 0;
    #1 check("post_rst_ready", in_ready, 1);

    // four lanes into one cell, single last beat from IDLE
    for (int i = 0; i < 4; i++) set_lane(i, 5, 10);
    beat(2, 8'h0F, 1);
    exp_acc[2][5] = 40;
    drain();

    // interleaved columns, negative data; masked-off lane 1
    set_lane(0, 0, -3); set_lane(1, 0, 50);
    beat(0, 8'h01, 0);
    set_lane(0, 0, -3);
    beat(1, 8'h01, 0);
    set_lane(0, 0, -3); set_lane(1, 0, 50);
    beat(0, 8'h01, 1);
    exp_acc[0][0] = -6;
    exp_acc[1][0] = -3;
    drain();

    // backpressure during drain, beat offered is refused
    set_lane(0, 3, 7); set_lane(1, 4, -1);
    beat(0, 8'h03, 0);
    set_lane(0, 2, 5);
    beat(1, 8'h01, 1);
    exp_acc[0][3] = 7;
    exp_acc[0][4] = -1;
    exp_acc[1][2] = 5;
    held = pack_col(0);
    set_lane(0, 0, 20);
    in_mask  = 8'h01;
    in_col   = '0;
    in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_col", out_col, 0);
      check("hold_data", out_data, held);
      check("hold_ready", in_ready, 0);
    end
    in_valid = 0;
    in_mask  = '0;
    in_data  = '0;
    in_row   = '0;
    drain();

    // out-of-range row and column are dropped
    set_lane(0, 0, 11);
    beat(N, 8'h01, 0);
    set_lane(0, M, 9); set_lane(1, 15, 1);
    beat(5, 8'h03, 1);
    drain();

    // three +100 beats into one cell
    for (int b = 0; b < 3; b++) begin
      set_lane(0, 6, 100);
      beat(4, 8'h01, b == 2);
    end
`ifdef USTC_PSUM_SAT_EN
    exp_acc[4][6] = 127;
    drain();
    check("sat_flag", sat_flag, 1);
`else
    exp_acc[4][6] = 44;
    drain();
    check("sat_flag", sat_flag, 0);
`endif

    // reset during drain at column 3 aborts the tile
    set_lane(0, 1, 4);
    beat(3, 8'h01, 0);
    set_lane(0, 0, 2);
    beat(0, 8'h01, 1);
    out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      check("abort_col", out_col, c);
      @(negedge clk);
    end
    check("abort_at3", out_col, 3);
    out_ready = 0;
    rst = 1;
    @(negedge clk);
    check("abort_valid", out_valid, 0);
    check("abort_ready", in_ready, 0);
    rst = 0;
    #1;
    check("abort_idle", in_ready, 1);
    check("abort_sat", sat_flag, 0);
    check("abort_col0", out_col, 0);
    set_lane(0, 2, 1);
    beat(2, 8'h01, 1);
    exp_acc[2][2] = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ustc_psum_accum_buf.md
USTC_PSUM_ACCUM_BUF -- requirements
Module: ustc_psum_accum_buf

Interface
REQ-001 SHALL have parameter M, default 16: rows per column (output height).
REQ-002 SHALL have parameter N, default 16: columns per tile.
REQ-003 SHALL have parameter NUM_IN, default 32: input lanes per beat.
REQ-004 SHALL have parameter DW_DATA, default 8: signed lane data width.
REQ-005 SHALL have parameter DW_ACC, default 16: signed accumulator width (DW_ACC >= DW_DATA).
REQ-006 SHALL have parameters DW_ROW and DW_COL, default 4 each: row and column index widths.
REQ-007 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-011 SHALL have port in_col, input, DW_COL bits: target column of the beat.
REQ-012 SHALL have port in_data, input, NUM_IN*DW_DATA bits: lane i at bits [i*DW_DATA +: DW_DATA].
REQ-013 SHALL have port in_row, input, NUM_IN*DW_ROW bits: per-lane row index.
REQ-014 SHALL have port in_mask, input, NUM_IN bits: per-lane enable.
REQ-015 SHALL have port in_last, input, 1 bit: final beat of the tile.
REQ-016 SHALL have port out_valid, output, 1 bit: an output column is valid.
REQ-017 SHALL have port out_ready, input, 1 bit: the downstream side accepts the column.
REQ-018 SHALL have port out_col, output, DW_COL bits: index of the column being output.
REQ-019 SHALL have port out_data, output, M*DW_ACC bits: row r at bits [r*DW_ACC +: DW_ACC].
REQ-020 SHALL have port sat_flag, output, 1 bit: sticky saturation indicator.

Function
REQ-021 SHALL use a state machine with states IDLE, ACCUM and DRAIN; it moves from IDLE to ACCUM on the first accepted beat, from ACCUM to DRAIN on an accepted beat with in_last=1, and from DRAIN to IDLE after column N-1 is handshaken.
REQ-022 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in DRAIN; a beat is accepted when in_valid && in_ready.
REQ-023 SHALL, for each accepted beat, add the sign-extended data of every masked lane into acc[in_col][row]; lanes that share a row in the same beat are summed together in a single update.
REQ-024 SHALL drop any lane with row >= M; SHALL accept and discard a whole beat with in_col >= N.
REQ-025 SHALL allow in_col to change arbitrarily between beats; no ordering of columns is required.
REQ-026 SHALL make the accumulation from a beat accepted in cycle t visible in acc at cycle t+1 (1-cycle latency).
REQ-027 SHALL include the in_last beat's data in the accumulators before the first output column is presented.
REQ-028 SHALL, in DRAIN, present columns 0..N-1 in order, with out_valid rising the cycle after the in_last beat is accepted.
REQ-029 SHALL hold out_col and out_data stable while out_valid=1 and out_ready=0.
REQ-030 SHALL clear each column's accumulators on that column's output handshake, so the block is empty on return to IDLE.
REQ-031 SHALL, for an in_last beat received in IDLE, accumulate it and go directly to DRAIN.

Reset
REQ-032 SHALL, on rst, clear all M*N accumulators to 0, enter state IDLE, and drive out_valid=0, out_col=0, sat_flag=0 and in_ready=0 during the reset cycle.
REQ-033 SHALL treat reset during DRAIN or ACCUM as an abort: remaining columns are not output and the data is lost.

Configuration
REQ-034 SHALL, with USTC_PSUM_SAT_EN defined, clamp each updated accumulator to the range [-2^(DW_ACC-1), 2^(DW_ACC-1)-1] and set sat_flag (sticky until rst) on any clamp event.
REQ-035 SHALL, without USTC_PSUM_SAT_EN, wrap accumulators modulo 2^DW_ACC and tie sat_flag to 0.

Structure
REQ-036 SHALL place the state enum (IDLE/ACCUM/DRAIN) and the default parameter constants in the shared package ustc_psum_pkg.
REQ-037 SHALL instantiate the sub-module ustc_psum_row_adder once per row; it performs the masked, row-matched reduction of NUM_IN lanes into one sum of width DW_ACC+clog2(NUM_IN).

Verification
REQ-038 SHALL cover: beat col=2, lanes 0..3 row=5 data=+10, mask=0xF, in_last=1 -> column 2 row 5 outputs 40, all other rows and columns output 0.
REQ-039 SHALL cover: three beats to col=0 and col=1 interleaved, data=-3 row=0 -> column 0 = -6 and column 1 = -3 when 2+1 beats are sent.
REQ-040 SHALL cover: out_ready held low for 5 cycles during DRAIN -> out_col/out_data stable, in_ready=0, and a beat offered during DRAIN is not accepted.
REQ-041 SHALL cover: with SAT_EN and DW_ACC=8, 3 beats of +100 to one cell -> output 127 and sat_flag=1; without SAT_EN -> output 44 and sat_flag=0.
REQ-042 SHALL cover: lane row=M and a beat with col=N -> the data is dropped and the output is all zeros.
REQ-043 SHALL cover: rst asserted at DRAIN column 3 -> out_valid=0 next cycle, IDLE, and a following tile outputs only its own data.
